// File: rtl/rr_arb_pkg.sv
// Shared types and rotate helpers for the 8-way round-robin arbiter.
// Rotation lets a fixed-priority encoder act as a pointer-based search.
package rr_arb_pkg;

   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Rotate right: bit 'sh' of v lands on bit 0.
   function automatic logic [NUM_REQ-1:0] rotr8(input logic [NUM_REQ-1:0] v,
                                                input logic [IDX_W-1:0]   sh);
      logic [2*NUM_REQ-1:0] w;
      w = {v, v} >> sh;
      return w[NUM_REQ-1:0];
   endfunction

   function automatic logic [NUM_REQ-1:0] rotl8(input logic [NUM_REQ-1:0] v,
                                                input logic [IDX_W-1:0]   sh);
      logic [2*NUM_REQ-1:0] w;
      w = {v, v} << sh;
      return w[2*NUM_REQ-1:NUM_REQ];
   endfunction

endpackage

// File: rtl/rr_arb8_pri_enc8.sv
// Combinational fixed-priority encoder, lowest set bit wins.
// Yields one-hot, binary index and an any-valid flag.
import rr_arb_pkg::*;

module pri_enc8 (
   input  logic [NUM_REQ-1:0] i_vec,
   output logic [NUM_REQ-1:0] o_onehot,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_valid
);

   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_valid  = 1'b0;
      // Walk downward so the lowest set bit is the last (winning) write.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_onehot    = '0;
            o_onehot[i] = 1'b1;
            o_idx       = IDX_W'(i);
            o_valid     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arb8.sv
// 8-requester round-robin arbiter with a per-owner hold limit and a
// mandatory dead cycle between grants. All outputs come straight from flops.
import rr_arb_pkg::*;

// state | meaning
// IDLE  | no owner; gnt=0; a request with en=1 is granted on the next edge
// GRANT | one owner holds gnt; released by done, req drop or hold limit

module rr_arb8 #(
   parameter int MAX_HOLD = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               busy,
   output logic               timeout
);

   localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_t               r_state,   w_state_nxt;
   logic [IDX_W-1:0]     r_ptr,     w_ptr_nxt;
   logic [HOLD_W-1:0]    r_hold,    w_hold_nxt;
   logic [NUM_REQ-1:0]   r_gnt,     w_gnt_nxt;
   logic [IDX_W-1:0]     r_idx,     w_idx_nxt;
   logic                 r_busy,    w_busy_nxt;
   logic                 r_timeout, w_timeout_nxt;

   logic [NUM_REQ-1:0]   w_req_rot;
   logic [NUM_REQ-1:0]   w_enc_onehot;
   logic [IDX_W-1:0]     w_enc_idx;
   logic                 w_enc_valid;
   logic [NUM_REQ-1:0]   w_sel_onehot;
   logic [IDX_W-1:0]     w_sel_idx;

   logic                 w_rel_done;
   logic                 w_rel_drop;
   logic                 w_rel_hold;

   assign w_req_rot = rotr8(req, r_ptr);

   pri_enc8 u_pri_enc8 (
      .i_vec    (w_req_rot),
      .o_onehot (w_enc_onehot),
      .o_idx    (w_enc_idx),
      .o_valid  (w_enc_valid)
   );

   assign w_sel_onehot = rotl8(w_enc_onehot, r_ptr);
   assign w_sel_idx    = w_enc_idx + r_ptr;

   assign w_rel_done = done;
   assign w_rel_drop = ~req[r_idx];
   assign w_rel_hold = (r_hold == HOLD_LAST);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_hold    <= '0;
         r_gnt     <= '0;
         r_idx     <= '0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_hold    <= w_hold_nxt;
         r_gnt     <= w_gnt_nxt;
         r_idx     <= w_idx_nxt;
         r_busy    <= w_busy_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_hold_nxt    = r_hold;
      w_gnt_nxt     = r_gnt;
      w_idx_nxt     = r_idx;
      w_busy_nxt    = r_busy;
      w_timeout_nxt = 1'b0;

      unique case (r_state)
         IDLE: begin
            w_gnt_nxt  = '0;
            w_busy_nxt = 1'b0;
            if (en && w_enc_valid) begin
               w_state_nxt = GRANT;
               w_gnt_nxt   = w_sel_onehot;
               w_idx_nxt   = w_sel_idx;
               w_busy_nxt  = 1'b1;
               w_hold_nxt  = '0;
            end
         end
         GRANT: begin
            if (w_rel_done || w_rel_drop || w_rel_hold) begin
               w_state_nxt   = IDLE;
               w_gnt_nxt     = '0;
               w_busy_nxt    = 1'b0;
               w_hold_nxt    = '0;
               w_ptr_nxt     = r_idx + IDX_W'(1);
               // Timeout flags only a release the owner did not ask for.
               w_timeout_nxt = w_rel_hold & ~w_rel_done & ~w_rel_drop;
            end else begin
               w_hold_nxt = r_hold + HOLD_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   assign gnt     = r_gnt;
   assign gnt_idx = r_idx;
   assign busy    = r_busy;
   assign timeout = r_timeout;

endmodule

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 Parameter MAX_HOLD, default 16: maximum consecutive GRANT cycles per owner before forced release; legal range 2..256.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  arbitration enable; when low, no new grant is issued.
REQ-005 req  input  8  request vector; bit i = requester i.
REQ-006 done  input  1  owner's release strobe; sampled only in GRANT.
REQ-007 gnt  output  8  registered one-hot grant, or all-zero.
REQ-008 gnt_idx  output  3  binary index of the current owner; valid only while busy=1.
REQ-009 busy  output  1  high exactly while state is GRANT.
REQ-010 timeout  output  1  one-cycle pulse on the cycle the grant is removed because of a hold-limit release.

Function
REQ-011 The FSM SHALL have two states: IDLE and GRANT.
REQ-012 In IDLE with en=1 and req!=0, the FSM SHALL select the first set req bit searching upward from ptr, wrapping 7->0, and enter GRANT on the next edge with gnt one-hot on that bit; latency 1 cycle.
REQ-013 In IDLE with en=0 or req=0, the FSM SHALL remain in IDLE with gnt=0.
REQ-014 In GRANT, gnt and gnt_idx SHALL remain stable until release.
REQ-015 Release from GRANT SHALL occur on a clock edge where done=1, or req[owner]=0, or hold count = MAX_HOLD-1; the FSM SHALL enter IDLE with gnt=0.
REQ-016 On release, ptr SHALL be loaded with (owner+1) mod 8, so 7 wraps to 0.
REQ-017 Every release SHALL be followed by at least one IDLE cycle with gnt=0 (dead cycle) before the next grant.
REQ-018 The hold counter SHALL clear on entry to GRANT and increment each GRANT cycle; width is clog2(MAX_HOLD), with no wrap before release.
REQ-019 timeout SHALL pulse only when the hold limit is the sole release cause; if done=1 or req[owner]=0 on the same edge, timeout SHALL remain 0.
REQ-020 en=0 during GRANT SHALL NOT revoke the current grant; it only blocks the next grant.
REQ-021 Changes to non-owner req bits during GRANT SHALL have no effect until IDLE.
REQ-022 done asserted in IDLE SHALL be ignored.
REQ-023 A requester holding req high continuously SHALL NOT be granted twice before every other continuously requesting bit has been granted once.

Reset
REQ-024 On reset_n=0, immediately and independent of clock: state=IDLE, gnt=0, gnt_idx=0, busy=0, timeout=0, ptr=0, hold counter=0.
REQ-025 Reset asserted mid-GRANT SHALL drop gnt within the same cycle, with no timeout pulse.
REQ-026 After reset_n deasserts, the first grant SHALL take 1 clock from a sampled request.

Structure
REQ-027 Package rr_arb_pkg SHALL hold NUM_REQ=8, IDX_W=3 and the state enum {IDLE, GRANT}.
REQ-028 Selection SHALL use one sub-module, pri_enc8: a combinational fixed-priority 8-bit encoder (lowest index wins) with outputs one-hot, index and any-valid.
REQ-029 rr_arb8 SHALL apply pri_enc8 to req rotated right by ptr, then rotate the result back by ptr.
REQ-030 All outputs SHALL be driven from flops; there SHALL be no combinational path from req, en or done to any output.

Verification
REQ-031 Reset, then req=8'h01, en=1 -> gnt=8'h01 and gnt_idx=0 one edge later; busy=1.
REQ-032 req=8'hFF held, done pulsed each GRANT cycle -> grant order 0,1,2,...,7,0 with one gnt=0 cycle between grants.
REQ-033 req=8'h81 held, owner=7 releases via done -> ptr=0, next grant = 8'h01 (wrap).
REQ-034 MAX_HOLD=4, req=8'h04 held, done=0 -> gnt=8'h04 for 4 cycles, then gnt=0 with timeout=1 for one cycle; next grant is bit 2 again (sole requester).
REQ-035 Owner bit 3 in GRANT, en=0, then req[3]=0 -> grant dropped, no new grant while en=0 even though req=8'h30.
REQ-036 reset_n pulsed low mid-GRANT between edges -> gnt=0 asynchronously, ptr=0, and first grant after release goes to the lowest set req bit.
